video_timing_gen: RTL

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_pkg.sv | 41 ++++
 rtl/timing_counter.sv | 37 +++
 rtl/video_timing_gen.sv | 109 ++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Video timing package.
// Holds the timing_t description of a video mode (four horizontal and four
// vertical segment lengths plus sync polarities), presets for common modes,
// and a helper that sums the four segments of one axis.
package video_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        h_pol;
    logic        v_pol;
  } timing_t;

  localparam timing_t TIMING_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
    h_pol: 1'b0, v_pol: 1'b0};

  localparam timing_t TIMING_800X600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
    h_pol: 1'b1, v_pol: 1'b1};

  localparam timing_t TIMING_1280X720_60 = '{
    h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
    v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
    h_pol: 1'b1, v_pol: 1'b1};

  // Length of one full axis: active + front porch + sync + back porch.
  function automatic int unsigned span_total(int unsigned act, int unsigned fp,
                                             int unsigned sync, int unsigned bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/timing_counter.sv
// One axis of the raster: a wrapping position counter plus region decode.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   inc         advance by one this cycle
//   cnt         current position 0..TOTAL-1
//   wrap        cnt is at TOTAL-1 (next increment returns to 0)
//   active      cnt < ACT_END
//   sync        SYNC_BEG <= cnt < SYNC_END
// Bounds are W+1 bits wide so a bound equal to 2**W is representable.
module timing_counter #(
  parameter int         W        = 12,
  parameter logic [W:0] TOTAL    = (W+1)'(800),
  parameter logic [W:0] ACT_END  = (W+1)'(640),
  parameter logic [W:0] SYNC_BEG = (W+1)'(656),
  parameter logic [W:0] SYNC_END = (W+1)'(752)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1'b1);

  assign wrap   = (cnt == LAST);
  assign active = ({1'b0, cnt} < ACT_END);
  assign sync   = ({1'b0, cnt} >= SYNC_BEG) && ({1'b0, cnt} < SYNC_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (inc) cnt <= wrap ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster video timing generator.
// Walks an (hc,vc) position through a full frame one pixel per enabled cycle
// and presents the registered position with its sync/enable/pulse decode one
// cycle later, so every output describes the same pixel.
// Ports:
//   clk_pix      pixel clock
//   rst_n        async active-low reset
//   en           advance one pixel this cycle
//   sx, sy       presented position within the full frame
//   hsync/vsync  sync outputs at H_POL/V_POL level during the sync region
//   de           presented position is visible
//   line_start   one-cycle pulse when a new sx==0 is presented
//   frame_start  one-cycle pulse when a new (0,0) is presented
module video_timing_gen
  import video_pkg::*;
#(
  parameter int   CORDW    = 12,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             en,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOT_I = int'(span_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int V_TOT_I = int'(span_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

  localparam logic [CORDW:0] H_TOTAL    = (CORDW+1)'(H_TOT_I);
  localparam logic [CORDW:0] V_TOTAL    = (CORDW+1)'(V_TOT_I);
  localparam logic [CORDW:0] H_ACT_END  = (CORDW+1)'(H_ACTIVE);
  localparam logic [CORDW:0] H_SYNC_BEG = (CORDW+1)'(H_ACTIVE + H_FP);
  localparam logic [CORDW:0] H_SYNC_END = (CORDW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW:0] V_ACT_END  = (CORDW+1)'(V_ACTIVE);
  localparam logic [CORDW:0] V_SYNC_BEG = (CORDW+1)'(V_ACTIVE + V_FP);
  localparam logic [CORDW:0] V_SYNC_END = (CORDW+1)'(V_ACTIVE + V_FP + V_SYNC);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_param
    $error("video_timing_gen: timing parameters must all be nonzero");
  end
  if (H_TOT_I > 2**CORDW || V_TOT_I > 2**CORDW) begin : g_total_range
    $error("video_timing_gen: H/V total exceeds 2**CORDW");
  end

  logic [CORDW-1:0] hc, vc;
  logic h_wrap, h_act, h_sy, v_act, v_sy;
  // End-of-frame carry of the vertical axis has no consumer here.
  logic v_wrap_unused;

  timing_counter #(
    .W(CORDW), .TOTAL(H_TOTAL), .ACT_END(H_ACT_END),
    .SYNC_BEG(H_SYNC_BEG), .SYNC_END(H_SYNC_END)
  ) u_h (
    .clk(clk_pix), .rst_n(rst_n), .inc(en),
    .cnt(hc), .wrap(h_wrap), .active(h_act), .sync(h_sy)
  );

  // Vertical advances only on the pixel that wraps the line.
  timing_counter #(
    .W(CORDW), .TOTAL(V_TOTAL), .ACT_END(V_ACT_END),
    .SYNC_BEG(V_SYNC_BEG), .SYNC_END(V_SYNC_END)
  ) u_v (
    .clk(clk_pix), .rst_n(rst_n), .inc(en & h_wrap),
    .cnt(vc), .wrap(v_wrap_unused), .active(v_act), .sync(v_sy)
  );

  // Outputs sample the counters on the same edge the counters advance, so the
  // presented pixel trails the counter by one cycle. Pulses are tied to en so
  // a held position never re-fires them.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      sx          <= '0;
      sy          <= '0;
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      sx          <= hc;
      sy          <= vc;
      hsync       <= h_sy ? H_POL : ~H_POL;
      vsync       <= v_sy ? V_POL : ~V_POL;
      de          <= h_act & v_act;
      line_start  <= (hc == '0);
      frame_start <= (hc == '0) && (vc == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule
